// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
//
// Consumer end of the record/playback sequencer. While the sequencer holds
// ld_note, each rising edge of ld_note stores one 3-bit note code into a
// 16-entry memory. While ld_play is high, the code addressed by note_counter
// is fetched on the ld_play rising edge and on every next_note_en tick, and a
// square wave of +/-AMP at that note's pitch is produced on audio_out.
//
// Optional feature (macro NOTE_PLAYER_GAP_EN): each fetch first passes
// through a GAP state of GAP_CYC silent cycles before the tone begins. With
// the macro undefined the GAP state does not exist and the tone starts on
// the cycle after the fetch.
//
// Ports:
//   clk           in   system clock (50 MHz)
//   reset         in   asynchronous, active-high; clears all state except
//                      the note memory
//   ld_note       in   level from sequencer; rising edge writes note_in
//   note_in       in   note code: 0 = rest, 1..7 = C4 D4 E4 F4 G4 A4 B4
//   ld_play       in   level from sequencer; high while playback is active
//   note_counter  in   playback address into the note memory
//   next_note_en  in   one-cycle tick requesting the next note
//   audio_out     out  signed square-wave sample
//   playing       out  high while a note is being played (PLAY or GAP)
//   cur_note      out  code currently sounding
//   notes_stored  out  number of writes, saturating at 15
// -----------------------------------------------------------------------------
module note_player #(
  parameter int                      AMP_W      = 16,
  parameter logic signed [AMP_W-1:0] AMP        = 16'sd8192,
  parameter int                      TONE_SHIFT = 0
`ifdef NOTE_PLAYER_GAP_EN
  ,
  parameter int                      GAP_CYC    = 2500000
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_note,
  input  logic [2:0]              note_in,
  input  logic                    ld_play,
  input  logic [3:0]              note_counter,
  input  logic                    next_note_en,
  output logic signed [AMP_W-1:0] audio_out,
  output logic                    playing,
  output logic [2:0]              cur_note,
  output logic [3:0]              notes_stored
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef NOTE_PLAYER_GAP_EN
    GAP,
`endif
    PLAY
  } state_t;

`ifdef NOTE_PLAYER_GAP_EN
  // A gap length below one cycle is treated as a single cycle so the
  // countdown always terminates.
  localparam int GAP_N = (GAP_CYC < 1) ? 1 : GAP_CYC;
  localparam int GW    = $clog2(GAP_N + 1);
`endif

  state_t      state;
  logic [2:0]  mem [16];
  logic [3:0]  wr_ptr;
  logic        ld_note_q;
  logic        ld_play_q;
  logic        ld_note_rise;
  logic        ld_play_rise;
  logic        do_fetch;
  logic [2:0]  fetch_code;
  logic [16:0] fetch_hp;
  logic [16:0] reload_hp;
  logic [16:0] tone_cnt;
  logic        phase;
`ifdef NOTE_PLAYER_GAP_EN
  logic [GW-1:0] gap_cnt;
`endif

  // Half-period in clock cycles for each note code, scaled down by
  // TONE_SHIFT. A non-rest note never maps to zero, otherwise the tone
  // counter would wrap instead of reloading.
  function automatic logic [16:0] half_period(input logic [2:0] code);
    logic [16:0] base;
    logic [16:0] scaled;
    case (code)
      3'd1:    base = 17'd95554;
      3'd2:    base = 17'd85132;
      3'd3:    base = 17'd75843;
      3'd4:    base = 17'd71586;
      3'd5:    base = 17'd63776;
      3'd6:    base = 17'd56818;
      3'd7:    base = 17'd50619;
      default: base = 17'd0;
    endcase
    scaled = base >> TONE_SHIFT;
    if ((code != 3'd0) && (scaled == 17'd0)) begin
      scaled = 17'd1;
    end
    return scaled;
  endfunction

  assign ld_note_rise = ld_note & ~ld_note_q;
  assign ld_play_rise = ld_play & ~ld_play_q;
  assign fetch_code   = mem[note_counter];
  assign fetch_hp     = half_period(fetch_code);
  assign reload_hp    = half_period(cur_note);
  assign notes_stored = wr_ptr;

  // A fetch starts from IDLE on a fresh ld_play edge, or from an active
  // note on a step tick. ld_note overrides everything, so no fetch is
  // possible while it is high.
  always_comb begin
    do_fetch = 1'b0;
    if (!ld_note) begin
      if (state == IDLE) begin
        do_fetch = ld_play_rise;
      end else if (state != LOAD) begin
        do_fetch = ld_play & next_note_en;
      end
    end
  end

  // Note memory has no reset so recorded notes survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ld_note_rise) begin
      mem[wr_ptr] <= note_in;
    end
  end

  // Sequencer state, write pointer and tone generator. ld_play_q resets
  // high so that an ld_play level held through reset does not look like a
  // new edge; playback only resumes after ld_play drops and rises again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= 4'd0;
      ld_note_q <= 1'b0;
      ld_play_q <= 1'b1;
      cur_note  <= 3'd0;
      audio_out <= '0;
      playing   <= 1'b0;
      tone_cnt  <= 17'd0;
      phase     <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      ld_note_q <= ld_note;
      ld_play_q <= ld_play;

      // The pointer sticks at 15 so later writes overwrite the last entry.
      if (ld_note_rise && (wr_ptr != 4'd15)) begin
        wr_ptr <= wr_ptr + 4'd1;
      end

      if (ld_note) begin
        state     <= LOAD;
        playing   <= 1'b0;
        audio_out <= '0;
      end else if (do_fetch) begin
        cur_note <= fetch_code;
        phase    <= 1'b0;
        playing  <= 1'b1;
        tone_cnt <= fetch_hp;
`ifdef NOTE_PLAYER_GAP_EN
        state     <= GAP;
        gap_cnt   <= GW'(GAP_N);
        audio_out <= '0;
`else
        state     <= PLAY;
        audio_out <= (fetch_code == 3'd0) ? '0 : AMP;
`endif
      end else begin
        case (state)
          IDLE: begin
          end
          LOAD: begin
            state <= IDLE;
          end
          PLAY: begin
            if (!ld_play) begin
              state     <= IDLE;
              playing   <= 1'b0;
              audio_out <= '0;
            end else if (cur_note != 3'd0) begin
              // Reloading at 1 rather than 0 makes each half exactly
              // half_period cycles long.
              if (tone_cnt == 17'd1) begin
                tone_cnt  <= reload_hp;
                phase     <= ~phase;
                audio_out <= phase ? AMP : -AMP;
              end else begin
                tone_cnt <= tone_cnt - 17'd1;
              end
            end
          end
`ifdef NOTE_PLAYER_GAP_EN
          GAP: begin
            if (!ld_play) begin
              state     <= IDLE;
              playing   <= 1'b0;
              audio_out <= '0;
            end else if (gap_cnt <= GW'(1)) begin
              state     <= PLAY;
              tone_cnt  <= reload_hp;
              phase     <= 1'b0;
              audio_out <= (cur_note == 3'd0) ? '0 : AMP;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
`endif
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// -----------------------------------------------------------------------------
// tb_note_player
//
// Randomised bench for note_player with TONE_SHIFT=10. A behavioural model
// keeps the note memory as an array and predicts the audio sample from the
// number of cycles since the last fetch: silent for the gap (if built with
// NOTE_PLAYER_GAP_EN), then alternating +AMP/-AMP blocks of one half-period.
// -----------------------------------------------------------------------------
module tb_note_player;

  localparam int AMP_W      = 16;
  localparam int AMP        = 8192;
  localparam int TONE_SHIFT = 10;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int GAP = 20;
`else
  localparam int GAP = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    ld_note = 1'b0;
  logic [2:0]              note_in = 3'd0;
  logic                    ld_play = 1'b0;
  logic [3:0]              note_counter = 4'd0;
  logic                    next_note_en = 1'b0;
  logic signed [AMP_W-1:0] audio_out;
  logic                    playing;
  logic [2:0]              cur_note;
  logic [3:0]              notes_stored;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int model_mem [16];
  int model_count;
  bit model_playing;
  bit prev_note;
  bit prev_play;
  int model_code;
  int model_k;
  int last_code;

  always #10 clk = ~clk;

`ifdef NOTE_PLAYER_GAP_EN
  note_player #(.TONE_SHIFT(TONE_SHIFT), .GAP_CYC(GAP)) dut (
`else
  note_player #(.TONE_SHIFT(TONE_SHIFT)) dut (
`endif
    .clk          (clk),
    .reset        (reset),
    .ld_note      (ld_note),
    .note_in      (note_in),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .next_note_en (next_note_en),
    .audio_out    (audio_out),
    .playing      (playing),
    .cur_note     (cur_note),
    .notes_stored (notes_stored)
  );

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int ref_half_period(input int code);
    int hp;
    case (code)
      1:       hp = 95554;
      2:       hp = 85132;
      3:       hp = 75843;
      4:       hp = 71586;
      5:       hp = 63776;
      6:       hp = 56818;
      7:       hp = 50619;
      default: hp = 0;
    endcase
    return hp >> TONE_SHIFT;
  endfunction

  function automatic int ref_audio();
    int blocks;
    if (!model_playing || model_code == 0 || model_k < GAP) return 0;
    blocks = (model_k - GAP) / ref_half_period(model_code);
    return (blocks % 2 == 0) ? AMP : -AMP;
  endfunction

  function automatic void model_reset();
    model_count   = 0;
    model_playing = 1'b0;
    prev_note     = 1'b0;
    prev_play     = 1'b1;
    model_code    = 0;
    model_k       = 0;
  endfunction

  function automatic void model_fetch(input int addr);
    model_code    = model_mem[addr];
    model_k       = 0;
    model_playing = 1'b1;
  endfunction

  // Drives one cycle of inputs, advances the model by one clock and
  // compares every output against it.
  task automatic applyStimulus(input bit ln, input int ni, input bit lp,
                               input int nc, input bit ne);
    ld_note      = ln;
    note_in      = 3'(ni);
    ld_play      = lp;
    note_counter = 4'(nc);
    next_note_en = ne;
    @(posedge clk);
    #1;
    if (ln) begin
      if (!prev_note) begin
        model_mem[model_count] = ni;
        if (model_count < 15) model_count++;
      end
      model_playing = 1'b0;
    end else if (!model_playing) begin
      if (lp && !prev_play && !prev_note) model_fetch(nc);
    end else if (!lp) begin
      model_playing = 1'b0;
    end else if (ne) begin
      model_fetch(nc);
    end else begin
      model_k++;
    end
    prev_note = ln;
    prev_play = lp;
    checkOutput("audio_out", int'(audio_out), ref_audio());
    checkOutput("playing", int'(playing), int'(model_playing));
    checkOutput("notes_stored", int'(notes_stored), model_count);
    if (model_playing) checkOutput("cur_note", int'(cur_note), model_code);
  endtask

  task automatic write_note(input int code);
    applyStimulus(1'b1, code, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, code, 1'b0, 0, 1'b0);
  endtask

  // Steps to a new address, then holds it for dwell cycles in total.
  task automatic play_note(input int addr, input int dwell);
    applyStimulus(1'b0, 0, 1'b1, addr, 1'b1);
    for (int i = 1; i < dwell; i++) applyStimulus(1'b0, 0, 1'b1, addr, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    model_reset();
    #25;
    checkOutput("reset_audio", int'(audio_out), 0);
    checkOutput("reset_playing", int'(playing), 0);
    checkOutput("reset_cur_note", int'(cur_note), 0);
    checkOutput("reset_notes_stored", int'(notes_stored), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Known first three entries: A4, C4, rest.
    write_note(6);
    write_note(1);
    write_note(0);
    checkOutput("stored_after_3", int'(notes_stored), 3);

    // 14 more random writes (17 total): pointer saturates at entry 15.
    for (int i = 0; i < 14; i++) begin
      last_code = int'($urandom_range(0, 7));
      write_note(last_code);
    end
    checkOutput("stored_saturated", int'(notes_stored), 15);

    // Start playback at address 0 (A4, 55-cycle half-period).
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);
    checkOutput("first_fetch_note", int'(cur_note), 6);
    checkOutput("first_fetch_audio", int'(audio_out), AMP);
    for (int i = 0; i < 240; i++) applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);

    // Rest keeps playing high with silent output.
    play_note(2, 12);
    checkOutput("rest_audio", int'(audio_out), 0);
    checkOutput("rest_playing", int'(playing), 1);

    // Random steps through the whole memory.
    for (int n = 0; n < 8; n++) begin
      play_note(int'($urandom_range(0, 15)), int'($urandom_range(1, 150)));
    end

    // Step tick lands on the tone reload edge: fetch wins, phase restarts.
    play_note(0, GAP + ref_half_period(model_mem[0]));
    play_note(15, 60);
    checkOutput("last_write_in_mem15", int'(cur_note), last_code);

    // Wrap of the address back to 0 is an ordinary fetch.
    play_note(0, 30);

    // Dropping ld_play stops playback on the next cycle.
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("stop_playing", int'(playing), 0);
    checkOutput("stop_audio", int'(audio_out), 0);

    // Reset in the middle of a tone.
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 20 + GAP; i++) applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_audio", int'(audio_out), 0);
    checkOutput("async_reset_playing", int'(playing), 0);
    checkOutput("async_reset_cur_note", int'(cur_note), 0);
    checkOutput("async_reset_stored", int'(notes_stored), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ld_play held high through reset must not restart playback.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);
    checkOutput("retained_mem1", int'(cur_note), 1);
    for (int i = 0; i < 120; i++) applyStimulus(1'b0, 0, 1'b1, 1, 1'b0);

    // ld_note beats ld_play: playback stops and entry 0 is overwritten.
    applyStimulus(1'b1, 5, 1'b1, 1, 1'b0);
    checkOutput("precedence_playing", int'(playing), 0);
    applyStimulus(1'b0, 5, 1'b1, 1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);
    checkOutput("overwritten_mem0", int'(cur_note), 5);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
